// File: rtl/io_tx_mailbox.sv
// CPU I/O-port mailbox: toggle-handshake posts bytes into a small FIFO,
// which is drained onto an 8N1 LSB-first serial line.
module io_tx_mailbox #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d0_s,
  input  logic [7:0] d1_s,
  input  logic [7:0] d2_s,
  input  logic [7:0] d3_s,
  output logic [7:0] d0_e,
  output logic [7:0] d1_e,
  output logic [7:0] d2_e,
  output logic [7:0] d3_e,
  output logic       tx
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count, count_nxt;
  logic            last_req, last_req_nxt;
  logic            pend, push, pop, bit_end, busy_nxt;

  logic [15:0] unused_in;
  assign unused_in = {d2_s, d3_s};

  always_comb begin
    pend         = d1_s[0] != last_req;
    push         = pend && (count < CNTW'(FIFO_DEPTH));
    bit_end      = bit_cnt == '0;
    pop          = d1_s[7] && (count != '0) &&
                   ((state == IDLE) || ((state == STOP) && bit_end));
    count_nxt    = count + CNTW'(push) - CNTW'(pop);
    last_req_nxt = push ? d1_s[0] : last_req;
    // Busy reflects the state after this edge so the status byte is never stale.
    busy_nxt     = (state == IDLE) ? pop : !((state == STOP) && bit_end && !pop);
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr] <= d0_s;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_req <= 1'b0;
      d0_e     <= 8'h10;
      d1_e     <= 8'h00;
      d2_e     <= 8'h00;
      d3_e     <= 8'h00;
    end else begin
      count    <= count_nxt;
      last_req <= last_req_nxt;
      d1_e     <= {7'b0, last_req_nxt};
      d0_e     <= {1'b0, d1_s[0] != last_req_nxt, busy_nxt, count_nxt == '0,
                   count_nxt == CNTW'(FIFO_DEPTH), 3'(count_nxt)};
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        d2_e   <= d0_s;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        shift  <= mem[rd_ptr];
      end
      case (state)
        IDLE: if (pop) begin
          state   <= START;
          tx      <= 1'b0;
          bit_cnt <= RELOAD;
        end
        START: if (bit_end) begin
          state   <= DATA;
          bit_idx <= '0;
          tx      <= shift[0];
          bit_cnt <= RELOAD;
        end else bit_cnt <= bit_cnt - CW'(1);
        DATA: if (bit_end) begin
          bit_cnt <= RELOAD;
          if (bit_idx == 3'd7) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            tx      <= shift[bit_idx + 3'd1];
          end
        end else bit_cnt <= bit_cnt - CW'(1);
        STOP: if (bit_end) begin
          d3_e    <= d3_e + 8'd1;
          bit_cnt <= RELOAD;
          // Chain straight into the next start bit when more data is waiting.
          if (pop) begin
            state <= START;
            tx    <= 1'b0;
          end else begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        end else bit_cnt <= bit_cnt - CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_tx_mailbox.sv
// Directed bench for io_tx_mailbox: handshake, FIFO stall, framing and reset.
module tb_io_tx_mailbox;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d0_s, d1_s, d2_s, d3_s;
  logic [7:0] d0_e, d1_e, d2_e, d3_e;
  logic       tx;
  logic       tog;
  int         tests = 0;
  int         fails = 0;

  io_tx_mailbox #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .d0_s(d0_s), .d1_s(d1_s), .d2_s(d2_s), .d3_s(d3_s),
    .d0_e(d0_e), .d1_e(d1_e), .d2_e(d2_e), .d3_e(d3_e), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; d0_s = 8'h00; d1_s = 8'h00; d2_s = 8'h00; d3_s = 8'h00; tog = 1'b0;
    repeat (3) step();
    reset = 1'b1;
  endtask

  task automatic post(input logic [7:0] b, input logic en);
    d0_s = b; tog = ~tog; d1_s = {en, 6'b0, tog};
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b exp 1", tx); end
    tests++; if (d0_e !== 8'h10) begin fails++; $display("FAIL reset_d0e got %h exp 10", d0_e); end
    tests++; if ({d1_e, d2_e, d3_e} !== 24'h0) begin fails++; $display("FAIL reset_d123e got %h exp 000000", {d1_e, d2_e, d3_e}); end
    repeat (10) step();
    tests++; if ({d0_e, d1_e, d2_e} !== 24'h100000) begin fails++; $display("FAIL idle_nopush got %h exp 100000", {d0_e, d1_e, d2_e}); end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    int bad;
    frame = {1'b1, 8'hA5, 1'b0};
    bad = 0;
    do_reset();
    post(8'hA5, 1'b1);
    step();
    tests++; if (d1_e !== 8'h01) begin fails++; $display("FAIL single_ack got %h exp 01", d1_e); end
    tests++; if (d2_e !== 8'hA5) begin fails++; $display("FAIL single_last got %h exp a5", d2_e); end
    tests++; if ({d0_e, tx} !== {8'h01, 1'b1}) begin fails++; $display("FAIL single_push_stat got %h/%b exp 01/1", d0_e, tx); end
    step();
    tests++; if ({d0_e, tx} !== {8'h30, 1'b0}) begin fails++; $display("FAIL single_start got %h/%b exp 30/0", d0_e, tx); end
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < 16; c++) begin
        if (tx !== frame[b]) bad++;
        step();
      end
    tests++; if (bad != 0) begin fails++; $display("FAIL single_bits got %0d bad cycles exp 0", bad); end
    tests++; if (d3_e !== 8'h01) begin fails++; $display("FAIL single_frames got %h exp 01", d3_e); end
    tests++; if ({d0_e, tx} !== {8'h10, 1'b1}) begin fails++; $display("FAIL single_idle got %h/%b exp 10/1", d0_e, tx); end
  endtask

  task automatic test_fifo_full();
    logic [9:0] fr;
    logic [7:0] prev_ack;
    int bad, f, b;
    bad = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) begin post(8'(i), 1'b0); step(); end
    tests++; if (d0_e !== 8'h0C) begin fails++; $display("FAIL full_stat got %h exp 0c", d0_e); end
    prev_ack = d1_e;
    post(8'h05, 1'b0);
    step();
    tests++; if (d0_e !== 8'h4C) begin fails++; $display("FAIL full_pending got %h exp 4c", d0_e); end
    tests++; if ({d1_e, d2_e} !== {prev_ack, 8'h04}) begin fails++; $display("FAIL full_noaccept got %h exp %h", {d1_e, d2_e}, {prev_ack, 8'h04}); end
    d1_s[7] = 1'b1;
    step();
    tests++; if ({d0_e, tx} !== {8'h63, 1'b0}) begin fails++; $display("FAIL full_firstpop got %h/%b exp 63/0", d0_e, tx); end
    step();
    tests++; if ({d0_e, d1_e, d2_e} !== {8'h2C, 7'b0, tog, 8'h05}) begin fails++; $display("FAIL full_late_accept got %h exp %h", {d0_e, d1_e, d2_e}, {8'h2C, 7'b0, tog, 8'h05}); end
    for (int t = 1; t < 800; t++) begin
      f = t / 160; b = (t % 160) / 16;
      fr = {1'b1, 8'(f + 1), 1'b0};
      if (tx !== fr[b]) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL b2b_bits got %0d bad cycles exp 0", bad); end
    tests++; if ({d3_e, d0_e, tx} !== {8'h05, 8'h10, 1'b1}) begin fails++; $display("FAIL b2b_done got %h/%h/%b exp 05/10/1", d3_e, d0_e, tx); end
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    post(8'h11, 1'b1); step();
    step();
    post(8'h22, 1'b1); step();
    repeat (158) step();
    tests++; if (d0_e !== 8'h21) begin fails++; $display("FAIL simul_pre got %h exp 21", d0_e); end
    post(8'h33, 1'b1);
    step();
    tests++; if ({d0_e, d2_e, d1_e} !== {8'h21, 8'h33, 8'h01}) begin fails++; $display("FAIL simul_stat got %h exp 213301", {d0_e, d2_e, d1_e}); end
    tests++; if ({d3_e, tx} !== {8'h01, 1'b0}) begin fails++; $display("FAIL simul_chain got %h/%b exp 01/0", d3_e, tx); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    bad = 0;
    do_reset();
    post(8'hAA, 1'b1); step();
    post(8'hBB, 1'b1); step();
    post(8'hCC, 1'b1); step();
    tests++; if (d0_e !== 8'h22) begin fails++; $display("FAIL rmid_queued got %h exp 22", d0_e); end
    repeat (68) step();
    reset = 1'b0;
    step();
    tests++; if ({tx, d0_e, d3_e} !== {1'b1, 8'h10, 8'h00}) begin fails++; $display("FAIL rmid_edge got %b/%h/%h exp 1/10/00", tx, d0_e, d3_e); end
    reset = 1'b1; d1_s = 8'h80; tog = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx !== 1'b1) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rmid_residual got %0d low cycles exp 0", bad); end
    tests++; if ({d0_e, d3_e} !== {8'h10, 8'h00}) begin fails++; $display("FAIL rmid_after got %h/%h exp 10/00", d0_e, d3_e); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    post(8'h5A, 1'b1); step();
    post(8'hC3, 1'b1); step();
    repeat (49) step();
    d1_s[7] = 1'b0;
    repeat (111) step();
    tests++; if ({d3_e, d0_e, tx} !== {8'h01, 8'h01, 1'b1}) begin fails++; $display("FAIL endrop_done got %h/%h/%b exp 01/01/1", d3_e, d0_e, tx); end
    repeat (20) step();
    tests++; if ({d3_e, d0_e, tx} !== {8'h01, 8'h01, 1'b1}) begin fails++; $display("FAIL endrop_hold got %h/%h/%b exp 01/01/1", d3_e, d0_e, tx); end
    d1_s[7] = 1'b1;
    step();
    tests++; if ({d0_e, tx} !== {8'h30, 1'b0}) begin fails++; $display("FAIL endrop_resume got %h/%b exp 30/0", d0_e, tx); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fifo_full();
    test_simul_push_pop();
    test_reset_mid_frame();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
